r_exec_seq: RTL

- Multi-cycle sequencer and datapath for R-type instructions.
- Fetches from the instruction memory and drives OP/func to the combinational R-type decoder.
- Consumes the decoder's ALU_OP/WE, reads the register file, executes the ALU operation and writes back.
- Sits directly around the decoder: it is both the decoder's source and the consumer of its output.

---
 rtl/r_exec_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/r_exec_seq.sv
// Multi-cycle IF/ID/EX/WB sequencer and datapath around an external R-type decoder.
// The sequencer feeds IR fields to the decoder, samples its outputs in ID, then executes and writes back.
module r_exec_seq #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  dec_op,
    output logic [5:0]  dec_func,
    input  logic [2:0]  dec_alu_op,
    input  logic        dec_we,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        zf,
    output logic        of,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        we_q, we_d;
    logic        zf_q, zf_d;
    logic        of_q, of_d;
    logic [31:0] rf_q [0:31];

    logic [31:0] rs_val, rt_val;
    logic [31:0] alu_res, sum, diff;
    logic        alu_ovf;
    logic        wb_wr;

    // r0 is hard-wired to zero on every read port
    assign rs_val = (ir_q[25:21] == 5'd0) ? 32'd0 : rf_q[ir_q[25:21]];
    assign rt_val = (ir_q[20:16] == 5'd0) ? 32'd0 : rf_q[ir_q[20:16]];

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        case (alu_op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q ^ b_q;
            3'b011: alu_res = ~(a_q | b_q);
            3'b100: begin
                alu_res = sum;
                alu_ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
            end
            3'b101: begin
                alu_res = diff;
                alu_ovf = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
            end
            3'b110: alu_res = {31'd0, (a_q < b_q)};
            3'b111: alu_res = b_q << a_q[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        alu_op_d  = alu_op_q;
        we_d      = we_q;
        zf_d      = zf_q;
        of_d      = of_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_IF;
            S_IF: begin
                ir_d    = imem_rdata;
                pc_d    = pc_q + PC_STEP;
                state_d = S_ID;
            end
            S_ID: begin
                a_d      = rs_val;
                b_d      = rt_val;
                alu_op_d = dec_alu_op;
                we_d     = dec_we & (ir_q[31:26] == 6'd0);
                state_d  = S_EX;
            end
            S_EX: begin
                alu_out_d = alu_res;
                zf_d      = (alu_res == 32'd0);
                of_d      = alu_ovf;
                state_d   = S_WB;
            end
            S_WB: state_d = run ? S_IF : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            alu_op_q  <= 3'd0;
            we_q      <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            alu_op_q  <= alu_op_d;
            we_q      <= we_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
        end
    end

    assign wb_wr = (state_q == S_WB) && we_q && (ir_q[15:11] != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (wb_wr) begin
            rf_q[ir_q[15:11]] <= alu_out_q;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dec_op    = ir_q[31:26];
    assign dec_func  = ir_q[5:0];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];
    assign retire    = (state_q == S_WB);
    assign zf        = zf_q;
    assign of        = of_q;
    assign busy      = (state_q != S_IDLE);

endmodule
